// File: rtl/i2c_ram_arbiter.sv
// Byte register file shared by an I2C slave (never stalls) and a local bus.
// A local access that collides with an I2C data write is parked and retried.
module i2c_ram_arbiter #(
    parameter int LD_NBYTES = 3
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 i2c_as,
    input  logic                 i2c_rs,
    input  logic                 i2c_ws,
    input  logic [7:0]           i2c_wdat,
    output logic [7:0]           i2c_rdat,
    input  logic                 lb_req,
    input  logic                 lb_we,
    input  logic [LD_NBYTES-1:0] lb_addr,
    input  logic [7:0]           lb_wdat,
    output logic                 lb_ack,
    output logic [7:0]           lb_rdat,
    output logic [7:0]           conflict_cnt
);

    localparam int NBYTES = 1 << LD_NBYTES;
    localparam logic [LD_NBYTES-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    logic [7:0]           mem_q [NBYTES];
    logic [7:0]           mem_d [NBYTES];
    logic [LD_NBYTES-1:0] idx_q, idx_d;
    logic                 as_seen_q, as_seen_d;
    state_t               state_q, state_d;
    logic                 lb_ack_q, lb_ack_d;
    logic [7:0]           lb_rdat_q, lb_rdat_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 p_we_q, p_we_d;
    logic [LD_NBYTES-1:0] p_addr_q, p_addr_d;
    logic [7:0]           p_wdat_q, p_wdat_d;

    logic                 conflict;
    logic                 do_acc;
    logic                 acc_we;
    logic [LD_NBYTES-1:0] acc_addr;
    logic [7:0]           acc_wdat;

    // Only an I2C data write touches mem, so only that cycle blocks the local bus.
    assign conflict = i2c_ws & ~i2c_rs & ~as_seen_q;

    always_comb begin
        mem_d     = mem_q;
        idx_d     = idx_q;
        as_seen_d = as_seen_q;
        state_d   = state_q;
        lb_ack_d  = 1'b0;
        lb_rdat_d = lb_rdat_q;
        cnt_d     = cnt_q;
        p_we_d    = p_we_q;
        p_addr_d  = p_addr_q;
        p_wdat_d  = p_wdat_q;
        do_acc    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdat  = '0;

        if (i2c_as) begin
            as_seen_d = 1'b1;
        end
        if (i2c_rs) begin
            idx_d     = idx_q + IDX_ONE;
            as_seen_d = 1'b0;
        end else if (i2c_ws) begin
            if (as_seen_q) begin
                idx_d     = i2c_wdat[LD_NBYTES-1:0];
                as_seen_d = 1'b0;
            end else begin
                mem_d[idx_q] = i2c_wdat;
                idx_d        = idx_q + IDX_ONE;
            end
        end

        case (state_q)
            IDLE: begin
                if (lb_req) begin
                    if (conflict) begin
                        p_we_d   = lb_we;
                        p_addr_d = lb_addr;
                        p_wdat_d = lb_wdat;
                        if (cnt_q != 8'hFF) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                        state_d = WAIT;
                    end else begin
                        do_acc   = 1'b1;
                        acc_we   = lb_we;
                        acc_addr = lb_addr;
                        acc_wdat = lb_wdat;
                        state_d  = ACK;
                    end
                end
            end
            WAIT: begin
                if (!conflict) begin
                    do_acc   = 1'b1;
                    acc_we   = p_we_q;
                    acc_addr = p_addr_q;
                    acc_wdat = p_wdat_q;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Applied after the I2C update so a deferred local write lands last.
        if (do_acc) begin
            lb_ack_d = 1'b1;
            if (acc_we) begin
                mem_d[acc_addr] = acc_wdat;
            end else begin
                lb_rdat_d = mem_q[acc_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem_q[i] <= '0;
            end
            idx_q     <= '0;
            as_seen_q <= 1'b0;
            state_q   <= IDLE;
            lb_ack_q  <= 1'b0;
            lb_rdat_q <= '0;
            cnt_q     <= '0;
            p_we_q    <= 1'b0;
            p_addr_q  <= '0;
            p_wdat_q  <= '0;
        end else begin
            mem_q     <= mem_d;
            idx_q     <= idx_d;
            as_seen_q <= as_seen_d;
            state_q   <= state_d;
            lb_ack_q  <= lb_ack_d;
            lb_rdat_q <= lb_rdat_d;
            cnt_q     <= cnt_d;
            p_we_q    <= p_we_d;
            p_addr_q  <= p_addr_d;
            p_wdat_q  <= p_wdat_d;
        end
    end

    assign i2c_rdat     = mem_q[idx_q];
    assign lb_ack       = lb_ack_q;
    assign lb_rdat      = lb_rdat_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Directed bench for i2c_ram_arbiter: a per-cycle vector table plus hand-written
// sequences for counter saturation and reset during a stalled access.
module tb_i2c_ram_arbiter;

    localparam int LD = 3;
    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_WAIT = 32'd1;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          i2c_as, i2c_rs, i2c_ws;
    logic [7:0]    i2c_wdat;
    logic [7:0]    i2c_rdat;
    logic          lb_req, lb_we;
    logic [LD-1:0] lb_addr;
    logic [7:0]    lb_wdat;
    logic          lb_ack;
    logic [7:0]    lb_rdat;
    logic [7:0]    conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    i2c_ram_arbiter #(.LD_NBYTES(LD)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .i2c_as       (i2c_as),
        .i2c_rs       (i2c_rs),
        .i2c_ws       (i2c_ws),
        .i2c_wdat     (i2c_wdat),
        .i2c_rdat     (i2c_rdat),
        .lb_req       (lb_req),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_wdat      (lb_wdat),
        .lb_ack       (lb_ack),
        .lb_rdat      (lb_rdat),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          as_s, rs_s, ws_s;
        logic [7:0]    wdat;
        logic          req, we;
        logic [LD-1:0] addr;
        logic [7:0]    lwd;
        logic          e_ack;
        logic [7:0]    e_rdat;
        logic [7:0]    e_cnt;
        logic [7:0]    e_lbr;
        logic [LD-1:0] e_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic a, logic r, logic w, logic [7:0] wd,
                                logic rq, logic we, logic [LD-1:0] ad, logic [7:0] lw,
                                logic eack, logic [7:0] erd, logic [7:0] ecnt,
                                logic [7:0] elbr, logic [LD-1:0] eidx);
        vec_t v;
        v.as_s = a; v.rs_s = r; v.ws_s = w; v.wdat = wd;
        v.req = rq; v.we = we; v.addr = ad; v.lwd = lw;
        v.e_ack = eack; v.e_rdat = erd; v.e_cnt = ecnt; v.e_lbr = elbr; v.e_idx = eidx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic r, input logic w, input logic [7:0] wd,
                         input logic rq, input logic we, input logic [LD-1:0] ad,
                         input logic [7:0] lw);
        i2c_as = a; i2c_rs = r; i2c_ws = w; i2c_wdat = wd;
        lb_req = rq; lb_we = we; lb_addr = ad; lb_wdat = lw;
    endtask

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic a, input logic r, input logic w, input logic [7:0] wd,
                        input logic rq, input logic we, input logic [LD-1:0] ad,
                        input logic [7:0] lw);
        drive(a, r, w, wd, rq, we, ad, lw);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ack"}, 32'(lb_ack), 32'd0);
        chk({tag, "_lbrdat"}, 32'(lb_rdat), 32'd0);
        chk({tag, "_cnt"}, 32'(conflict_cnt), 32'd0);
        chk({tag, "_i2crdat"}, 32'(i2c_rdat), 32'd0);
        chk({tag, "_idx"}, 32'(dut.idx_q), 32'd0);
        chk({tag, "_asseen"}, 32'(dut.as_seen_q), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), ST_IDLE);
        for (int i = 0; i < (1 << LD); i++) begin
            chk($sformatf("%s_mem%0d", tag, i), 32'(dut.mem_q[i]), 32'd0);
        end
    endtask

    initial begin
        int exp_cnt;

        aresetn = 1'b0;
        drive(0, 0, 0, 8'h00, 0, 0, '0, 8'h00);
        #12;
        chk_reset_values("rst0");
        @(negedge clk);
        aresetn = 1'b1;

        //              as rs ws wdat   rq we ad lwd    ack rdat   cnt    lbrdat idx
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 8'h10, 1, 8'h10, 8'd0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h10, 8'd0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h21, 1, 8'h10, 8'd0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h10, 8'd0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h10, 8'd0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 8'h05, 0, 0, 0, 8'h00, 0, 8'h00, 8'd0, 8'h00, 5));
        vecs.push_back(mk(0, 0, 1, 8'hAA, 0, 0, 0, 8'h00, 0, 8'h00, 8'd0, 8'h00, 6));
        vecs.push_back(mk(0, 0, 1, 8'hBB, 0, 0, 0, 8'h00, 0, 8'h00, 8'd0, 8'h00, 7));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h10, 8'd0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 3, 8'h5C, 1, 8'h21, 8'd0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 1, 8'h21, 8'd0, 8'h5C, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd0, 8'h5C, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 5, 8'h00, 1, 8'h21, 8'd0, 8'hAA, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd0, 8'hAA, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 6, 8'h00, 1, 8'h21, 8'd0, 8'hBB, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd0, 8'hBB, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd0, 8'hBB, 1));
        vecs.push_back(mk(0, 0, 1, 8'hF2, 0, 0, 0, 8'h00, 0, 8'h00, 8'd0, 8'hBB, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 2, 8'h77, 1, 8'h77, 8'd0, 8'hBB, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h77, 8'd0, 8'hBB, 2));
        vecs.push_back(mk(0, 0, 1, 8'h11, 1, 1, 2, 8'h22, 0, 8'h5C, 8'd1, 8'hBB, 3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 2, 8'h22, 1, 8'h5C, 8'd1, 8'hBB, 3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h5C, 8'd1, 8'hBB, 3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 2, 8'h00, 1, 8'h5C, 8'd1, 8'h22, 3));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h5C, 8'd1, 8'h22, 3));
        vecs.push_back(mk(0, 1, 1, 8'hEE, 1, 0, 0, 8'h00, 1, 8'h00, 8'd1, 8'h10, 4));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'd1, 8'h10, 4));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 3, 8'h00, 1, 8'h00, 8'd1, 8'h5C, 4));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'd1, 8'h5C, 4));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'd1, 8'h5C, 4));
        vecs.push_back(mk(0, 0, 1, 8'h07, 0, 0, 0, 8'h00, 0, 8'h00, 8'd1, 8'h5C, 7));
        vecs.push_back(mk(0, 0, 1, 8'h99, 0, 0, 0, 8'h00, 0, 8'h10, 8'd1, 8'h5C, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 7, 8'h00, 1, 8'h10, 8'd1, 8'h99, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h10, 8'd1, 8'h99, 0));
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h21, 8'd1, 8'h99, 1));
        vecs.push_back(mk(0, 0, 1, 8'h44, 0, 0, 0, 8'h00, 0, 8'h22, 8'd1, 8'h99, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1, 8'h22, 8'd1, 8'h44, 2));
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h22, 8'd1, 8'h44, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].as_s, vecs[i].rs_s, vecs[i].ws_s, vecs[i].wdat,
                 vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].lwd);
            chk($sformatf("v%0d_ack", i), 32'(lb_ack), 32'(vecs[i].e_ack));
            chk($sformatf("v%0d_i2crdat", i), 32'(i2c_rdat), 32'(vecs[i].e_rdat));
            chk($sformatf("v%0d_cnt", i), 32'(conflict_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_lbrdat", i), 32'(lb_rdat), 32'(vecs[i].e_lbr));
            chk($sformatf("v%0d_idx", i), 32'(dut.idx_q), 32'(vecs[i].e_idx));
        end

        // Forced conflicts: counter starts at 1 from the table and must stop at 255.
        exp_cnt = 1;
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 1, 8'(i), 1, 0, 0, 8'h00);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk($sformatf("sat%0d_state", i), 32'(dut.state_q), ST_WAIT);
            chk($sformatf("sat%0d_cnt", i), 32'(conflict_cnt), 32'(exp_cnt));
            chk($sformatf("sat%0d_noack", i), 32'(lb_ack), 32'd0);
            step(0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
            chk($sformatf("sat%0d_ack", i), 32'(lb_ack), 32'd1);
            step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
            chk($sformatf("sat%0d_ackdone", i), 32'(lb_ack), 32'd0);
        end

        // Reset asserted while a local write sits in WAIT.
        step(0, 0, 1, 8'h3C, 1, 1, 4, 8'h66);
        chk("rstw_state", 32'(dut.state_q), ST_WAIT);
        #2;
        aresetn = 1'b0;
        #1;
        chk_reset_values("rstw");
        drive(0, 0, 0, 8'h00, 1, 1, 4, 8'h66);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rstw_hold%0d_ack", i), 32'(lb_ack), 32'd0);
            chk($sformatf("rstw_hold%0d_mem4", i), 32'(dut.mem_q[4]), 32'd0);
        end
        @(negedge clk);
        aresetn = 1'b1;
        // First edge after release samples a read of the aborted address.
        step(0, 0, 0, 8'h00, 1, 0, 4, 8'h00);
        chk("post_rst_ack", 32'(lb_ack), 32'd1);
        chk("post_rst_lbrdat", 32'(lb_rdat), 32'd0);
        chk("post_rst_cnt", 32'(conflict_cnt), 32'd0);
        step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        chk("post_rst_ackdone", 32'(lb_ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
